// File: rtl/input_matrix_loader.sv
// Streams matrix headers and rows from a host into the input SRAM, appends an
// end marker, then launches the convolution engine and waits for it to finish.
module input_matrix_loader #(
  parameter logic [11:0] BASE_ADDR  = 12'h000,
  parameter logic [15:0] END_MARKER = 16'h00FF,
  parameter logic [11:0] MAX_ADDR   = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        load_start,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [15:0] host_data,
  input  logic        host_last,
  output logic [11:0] ldr_sram_write_address,
  output logic [15:0] ldr_sram_write_data,
  output logic        ldr_sram_write_enable,
  output logic        dut_run,
  input  logic        dut_busy,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    IDLE, NROWS, NCOLS, DATA, MARK, RUN, WAIT_HI, WAIT_LO
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] ptr_q, ptr_d;
  logic [4:0]  rows_q, rows_d;
  logic [4:0]  cols_q, cols_d;
  logic [4:0]  row_cnt_q, row_cnt_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        done_q, done_d;

  logic        accept;
  logic        hdr_ok;
  logic [15:0] row_mask;

  assign host_ready = (state_q == NROWS) || (state_q == NCOLS) || (state_q == DATA);
  assign accept     = host_valid & host_ready;
  assign hdr_ok     = (host_data >= 16'd3) && (host_data <= 16'd16);

  // Only the low C bits of a row word are meaningful.
  always_comb begin
    row_mask = '0;
    for (int i = 0; i < 16; i++) begin
      row_mask[i] = (i < int'(cols_q));
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_cnt_d = row_cnt_q;
    err_d     = err_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = NROWS;
          ptr_d   = BASE_ADDR;
          err_d   = 1'b0;
        end
      end
      NROWS, NCOLS, DATA: begin
        if (accept) begin
          // The last address is reserved for the terminator.
          if (ptr_q == MAX_ADDR) begin
            err_d   = 1'b1;
            state_d = MARK;
          end else begin
            we_d   = 1'b1;
            addr_d = ptr_q;
            data_d = (state_q == DATA) ? (host_data & row_mask) : host_data;
            ptr_d  = ptr_q + 12'd1;
            if (state_q == DATA) begin
              row_cnt_d = row_cnt_q - 5'd1;
              if (row_cnt_q == 5'd1) begin
                state_d = host_last ? MARK : NROWS;
              end
            end else if (!hdr_ok) begin
              err_d   = 1'b1;
              state_d = MARK;
            end else if (state_q == NROWS) begin
              rows_d  = host_data[4:0];
              state_d = NCOLS;
            end else begin
              cols_d    = host_data[4:0];
              row_cnt_d = rows_q;
              state_d   = DATA;
            end
          end
        end
      end
      MARK: begin
        we_d   = 1'b1;
        addr_d = ptr_q;
        data_d = END_MARKER;
        if (err_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: state_d = WAIT_HI;
      WAIT_HI: begin
        if (dut_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!dut_busy) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      ptr_q     <= BASE_ADDR;
      rows_q    <= '0;
      cols_q    <= '0;
      row_cnt_q <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_cnt_q <= row_cnt_d;
      err_q     <= err_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign ldr_sram_write_enable  = we_q;
  assign ldr_sram_write_address = addr_q;
  assign ldr_sram_write_data    = data_q;
  assign dut_run                = (state_q == RUN);
  assign load_done              = done_q;
  assign load_err               = err_q;

endmodule

// File: tb/tb_input_matrix_loader.sv
// Randomized self-checking bench for input_matrix_loader: beat streams are
// scored against a matrix-level reference model of the expected SRAM writes.
module tb_input_matrix_loader;

  localparam logic [15:0] END_MARKER = 16'h00FF;
  localparam int          MAX_ADDR   = 12'hFFF;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        load_start_a, load_start_b;
  logic        host_valid;
  logic [15:0] host_data;
  logic        host_last;
  logic        dut_busy;

  logic        ready_a, we_a, run_a, done_a, err_a;
  logic [11:0] addr_a;
  logic [15:0] data_a;
  logic        ready_b, we_b, run_b, done_b, err_b;
  logic [11:0] addr_b;
  logic [15:0] data_b;

  int checks = 0;
  int failures = 0;

  logic [15:0] beats[$];
  bit          lasts[$];
  logic [11:0] exp_addr[$];
  logic [15:0] exp_data[$];
  int          exp_consumed;
  bit          exp_err;
  int          m_addr;

  logic [11:0] got_addr[$];
  logic [15:0] got_data[$];
  int          run_cnt = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  input_matrix_loader dut_a (
    .clk(clk), .reset_b(reset_b), .load_start(load_start_a),
    .host_valid(host_valid), .host_ready(ready_a), .host_data(host_data),
    .host_last(host_last), .ldr_sram_write_address(addr_a),
    .ldr_sram_write_data(data_a), .ldr_sram_write_enable(we_a),
    .dut_run(run_a), .dut_busy(dut_busy), .load_done(done_a), .load_err(err_a)
  );

  input_matrix_loader #(.BASE_ADDR(12'hFFD)) dut_b (
    .clk(clk), .reset_b(reset_b), .load_start(load_start_b),
    .host_valid(host_valid), .host_ready(ready_b), .host_data(host_data),
    .host_last(host_last), .ldr_sram_write_address(addr_b),
    .ldr_sram_write_data(data_b), .ldr_sram_write_enable(we_b),
    .dut_run(run_b), .dut_busy(dut_busy), .load_done(done_b), .load_err(err_b)
  );

  // Record every SRAM write and pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (we_a) begin got_addr.push_back(addr_a); got_data.push_back(data_a); end
    if (we_b) begin got_addr.push_back(addr_b); got_data.push_back(data_b); end
    if (run_a || run_b) run_cnt++;
    if (done_a || done_b) done_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
    end
  endtask

  // Reference model: emits one write per header/row word, stops on a bad
  // header, a final row flagged last, or reaching the reserved top address.
  function automatic bit put_word(input logic [15:0] w);
    if (m_addr == MAX_ADDR) begin
      exp_err = 1'b1;
      return 1'b1;
    end
    exp_addr.push_back(12'(m_addr));
    exp_data.push_back(w);
    m_addr++;
    return 1'b0;
  endfunction

  function automatic void model(input logic [11:0] base);
    int i = 0;
    bit stop = 1'b0;
    int r, c;
    exp_addr.delete();
    exp_data.delete();
    exp_err = 1'b0;
    m_addr  = int'(base);
    while (!stop && i + 1 < beats.size()) begin
      r = int'(beats[i]);
      i++;
      if (put_word(beats[i-1])) break;
      if (r < 3 || r > 16) begin exp_err = 1'b1; break; end
      c = int'(beats[i]);
      i++;
      if (put_word(beats[i-1])) break;
      if (c < 3 || c > 16) begin exp_err = 1'b1; break; end
      for (int k = 0; k < r && !stop; k++) begin
        i++;
        if (put_word(beats[i-1] & 16'((32'h1 << c) - 1))) stop = 1'b1;
        else if (k == r - 1 && lasts[i-1]) stop = 1'b1;
      end
    end
    exp_consumed = i;
    exp_addr.push_back(12'(m_addr));
    exp_data.push_back(END_MARKER);
  endfunction

  function automatic int pick_dim(input int bad_pct);
    if ($urandom_range(99) < bad_pct)
      return ($urandom_range(1) == 0) ? int'($urandom_range(2)) : int'($urandom_range(40, 17));
    return int'($urandom_range(16, 3));
  endfunction

  task automatic build_random(input int n_mat, input int bad_pct);
    int r, c, nrows;
    beats.delete();
    lasts.delete();
    for (int m = 0; m < n_mat; m++) begin
      r = pick_dim(bad_pct);
      c = pick_dim(bad_pct);
      nrows = (r >= 3 && r <= 16) ? r : 3;
      beats.push_back(16'(r)); lasts.push_back(1'($urandom));
      beats.push_back(16'(c)); lasts.push_back(1'($urandom));
      for (int k = 0; k < nrows; k++) begin
        beats.push_back(16'($urandom));
        lasts.push_back((k == nrows - 1) ? (m == n_mat - 1) : 1'($urandom));
      end
    end
  endtask

  task automatic drive_junk();
    host_valid = 1'($urandom);
    host_data  = 16'($urandom);
    host_last  = 1'($urandom);
  endtask

  // Offer beats with random idle cycles; a stray load_start rides along
  // with some accepted beats and must be ignored.
  task automatic feed_beats(input bit sel, input int n, input int stall_pct);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < n && guard < 3000) begin
      @(negedge clk);
      guard++;
      load_start_a = 1'b0;
      load_start_b = 1'b0;
      if ($urandom_range(99) < stall_pct) begin
        host_valid = 1'b0;
        host_data  = 16'($urandom);
        host_last  = 1'($urandom);
      end else begin
        host_valid = 1'b1;
        host_data  = beats[idx];
        host_last  = lasts[idx];
        acc = sel ? ready_b : ready_a;
        if (acc && $urandom_range(5) == 0) begin
          if (sel) load_start_b = 1'b1; else load_start_a = 1'b1;
        end
        @(posedge clk);
        if (acc) idx++;
      end
    end
    @(negedge clk);
    host_valid   = 1'b0;
    load_start_a = 1'b0;
    load_start_b = 1'b0;
    checkOutput("beats_accepted", 32'(idx), 32'(n));
  endtask

  task automatic applyStimulus(input bit sel, input int stall_pct, input int busy_len);
    int start_w, start_run, start_done, guard;
    model(sel ? 12'hFFD : 12'h000);
    start_w    = got_addr.size();
    start_run  = run_cnt;
    start_done = done_cnt;
    @(negedge clk);
    if (sel) load_start_b = 1'b1; else load_start_a = 1'b1;
    @(negedge clk);
    load_start_a = 1'b0;
    load_start_b = 1'b0;
    checkOutput("err_cleared", 32'(sel ? err_b : err_a), 32'(0));
    feed_beats(sel, exp_consumed, stall_pct);
    if (!exp_err) begin
      guard = 0;
      while (run_cnt == start_run && guard < 30) begin
        @(negedge clk); drive_junk(); guard++;
      end
      checkOutput("run_seen", 32'(run_cnt - start_run), 32'(1));
      repeat ($urandom_range(2)) begin @(negedge clk); drive_junk(); end
      dut_busy = 1'b1;
      repeat (busy_len) begin @(negedge clk); drive_junk(); end
      checkOutput("no_early_done", 32'(done_cnt - start_done), 32'(0));
      dut_busy = 1'b0;
    end
    guard = 0;
    while (done_cnt == start_done && guard < 30) begin
      @(negedge clk); drive_junk(); guard++;
    end
    repeat (3) begin @(negedge clk); drive_junk(); end
    host_valid = 1'b0;
    checkOutput("done_pulses", 32'(done_cnt - start_done), 32'(1));
    checkOutput("run_pulses", 32'(run_cnt - start_run), 32'(exp_err ? 0 : 1));
    checkOutput("load_err", 32'(sel ? err_b : err_a), 32'(exp_err));
    checkOutput("write_count", 32'(got_addr.size() - start_w), 32'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (start_w + k < got_addr.size()) begin
        checkOutput("wr_addr", 32'(got_addr[start_w+k]), 32'(exp_addr[k]));
        checkOutput("wr_data", 32'(got_data[start_w+k]), 32'(exp_data[k]));
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checkOutput({tag, "_ready"}, 32'(ready_a), 32'(0));
    checkOutput({tag, "_we"}, 32'(we_a), 32'(0));
    checkOutput({tag, "_addr"}, 32'(addr_a), 32'(0));
    checkOutput({tag, "_data"}, 32'(data_a), 32'(0));
    checkOutput({tag, "_run"}, 32'(run_a), 32'(0));
    checkOutput({tag, "_done"}, 32'(done_a), 32'(0));
    checkOutput({tag, "_err"}, 32'(err_a), 32'(0));
  endtask

  initial begin
    int s;
    reset_b = 1'b0;
    load_start_a = 1'b0;
    load_start_b = 1'b0;
    host_valid = 1'b0;
    host_data = '0;
    host_last = 1'b0;
    dut_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_b = 1'b1;

    // Single 3x3 matrix with a row needing masking.
    beats = '{16'd3, 16'd3, 16'hFFFF, 16'h0005, 16'h0002};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b0, 0, 10);
    checkOutput("single_masked_row", 32'(got_data[got_data.size()-4]), 32'h0007);
    checkOutput("single_marker_addr", 32'(got_addr[got_addr.size()-1]), 32'h005);

    // 3x4 then 4x16; host_last high on matrix 1 except its final row.
    beats = '{16'd3, 16'd4, 16'h1234, 16'hABCD, 16'hFFFF,
              16'd4, 16'd16, 16'h8001, 16'h7FFE, 16'hFFFF, 16'h0000};
    lasts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b0, 0, 5);
    checkOutput("two_marker_addr", 32'(got_addr[got_addr.size()-1]), 32'h00B);
    checkOutput("two_full_width_row", 32'(got_data[got_data.size()-4]), 32'h7FFE);

    // Bad row count: header written, marker follows, no engine launch.
    beats = '{16'd2, 16'd5, 16'h1111, 16'h2222};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b0, 0, 4);
    checkOutput("bad_hdr_word", 32'(got_data[got_data.size()-2]), 32'h0002);
    checkOutput("bad_hdr_marker", 32'(got_data[got_data.size()-1]), 32'h00FF);

    // Random multi-matrix loads with stalls and occasional bad headers.
    for (int t = 0; t < 15; t++) begin
      build_random(int'($urandom_range(3, 1)), 12);
      applyStimulus(1'b0, int'($urandom_range(50)), int'($urandom_range(12, 3)));
    end

    // Reset while the row at address 7 is being written.
    beats = '{16'd8, 16'd4, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk); load_start_a = 1'b1;
    @(negedge clk); load_start_a = 1'b0;
    feed_beats(1'b0, 8, 0);
    checkOutput("pre_reset_we", 32'(we_a), 32'(1));
    checkOutput("pre_reset_addr", 32'(addr_a), 32'h007);
    #2 reset_b = 1'b0;
    #1 check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    s = got_addr.size();
    build_random(1, 0);
    applyStimulus(1'b0, 20, 5);
    if (got_addr.size() > s) checkOutput("post_reset_first_addr", 32'(got_addr[s]), 32'h000);
    else checkOutput("post_reset_writes", 32'(got_addr.size()), 32'(s + 1));

    // Load starting near the top of the SRAM runs into the reserved address.
    beats = '{16'd3, 16'd3, 16'h0001, 16'h0002, 16'h0003};
    lasts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b1, 0, 4);
    checkOutput("top_marker_addr", 32'(got_addr[got_addr.size()-1]), 32'hFFF);
    checkOutput("top_err", 32'(err_b), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
